servo_pwm_bank: RTL and testbench
=================================

# servo_pwm_bank

Multi-channel servo PWM generator. It is the parametrised successor to the single-channel servo drive. It has N independent outputs sharing one period counter, a write port for pulse-width targets, clamping to legal servo limits, glitch-free updates only at period boundaries, optional per-period slew limiting, and a boundary-synchronised enable. It sits between the forklift control processor's register interface and the steering/lift servo pins.

## Interface
- NUM_CH, 4: number of PWM channels (1..16).
- CH_W, 2: width of the channel index, ≥ clog2(NUM_CH).
- CNT_W, 32: width of the counter and pulse values.
- PERIOD, 2000000: clocks per PWM frame (20 ms at 100 MHz); ≥ 4.
- MIN_PULSE, 100000: lowest legal active width, in clocks.
- MAX_PULSE, 200000: highest legal active width, in clocks; MIN_PULSE ≤ MAX_PULSE < PERIOD.
- NEUTRAL, 150000: reset width for every channel; must lie within [MIN_PULSE, MAX_PULSE].
- SLEW_STEP, 0: maximum change of the active width per frame; 0 means an immediate jump.

Ports:
- clock_clk, in, 1: single system clock, rising edge.
- reset_low, in, 1: asynchronous, active-low reset.
- enable, in, 1: request to drive the outputs.
- wr_valid, in, 1: a target write is offered.
- wr_ready, out, 1: the write can be accepted this cycle.
- wr_ch, in, CH_W: channel index for the write.
- wr_pulse, in, CNT_W: requested pulse width, in clocks.
- pwm_out, out, NUM_CH: registered PWM outputs, one bit per channel.
- frame_start, out, 1: one-cycle pulse at the first cycle of each frame.
- settled, out, NUM_CH: per channel, high when the active width equals the target.

## Operation
- Frame counter `cnt` counts 0..PERIOD-1 and then wraps to 0. It runs whenever reset is released, regardless of enable.
- Per-channel registers:
  - `tgt`: the written target.
  - `act`: the width in use for the current frame.
- Write handshake:
  - A write is accepted when wr_valid && wr_ready.
  - wr_ready = 1 except in the cycle where cnt == PERIOD-1. That cycle is reserved for the tgt→act transfer.
  - Accepted value is clamped: < MIN_PULSE → MIN_PULSE; > MAX_PULSE → MAX_PULSE.
  - wr_ch ≥ NUM_CH: the write is accepted and dropped, and no state changes.
  - Back-to-back writes are allowed one per cycle; the last write to a channel wins.
- Frame-boundary update, on the edge where cnt goes PERIOD-1 → 0, for each channel:
  - SLEW_STEP == 0: act ← tgt.
  - Otherwise act moves toward tgt by min(SLEW_STEP, |tgt−act|). Never overshoot.
- Enable:
  - `en_q` samples `enable` only at the frame boundary. Mid-frame changes take effect in the next frame, so no runt or truncated pulses are produced.
  - While en_q = 0, pwm_out = 0, and act still updates at each boundary.
- Output: pwm_out[i] = en_q && (cnt < act[i]). The comparison is unsigned CNT_W.
- settled[i] = (act[i] == tgt[i]). It is combinational from the registers.
- frame_start = (cnt == 0).

## Timing
- Reset values:
  - cnt = 0, en_q = 0, pwm_out = 0.
  - tgt = act = NEUTRAL for every channel.
  - settled = all ones; wr_ready = 1; frame_start = 1, because cnt = 0.
- pwm_out is registered from the next-state values of cnt, act and en_q. Its high time therefore aligns exactly with cnt ∈ [0, act−1] of the same frame: exactly act clocks high per frame, then PERIOD−act clocks low.
- Write-to-output latency: a write accepted in frame k applies from frame k+1. With slew enabled, it reaches the target after ceil(|Δ|/SLEW_STEP) frames.
- A write in the cycle cnt == PERIOD-1 cannot happen because wr_ready is low. The master must hold wr_valid and the write lands at cnt = 0.
- If reset_low is asserted mid-frame, all outputs drop low immediately (asynchronously). On release, the first frame starts at cnt = 0 with en_q = 0. Outputs therefore stay low until the first boundary at which enable is seen high.
- Simultaneous write and boundary transfer are impossible by construction.

## Test plan
Bench parameters: NUM_CH=2, PERIOD=10, MIN_PULSE=2, MAX_PULSE=8, NEUTRAL=5, SLEW_STEP=0 unless stated.

- **Reset and enable:** release reset with enable=1 → frame 0 is all low. From frame 1, both pwm_out bits are high for 5 clocks and low for 5. frame_start pulses every 10 clocks.
- **Write and clamp:**
  - Write ch0=12 → from the next frame, 8 clocks high; settled[0]=1 after the boundary.
  - Write ch1=0 → 2 clocks high.
- **Handshake at boundary:** hold wr_valid with ch0=3 across cnt=9 → wr_ready=0 at cnt=9, accept at cnt=0. The new width appears one frame later; ch1 is unaffected.
- **Slew (SLEW_STEP=1):** act=5, write 8 → successive frames give 6, 7, 8 clocks high. settled[0]=0 until the frame with 8.
- **Mid-frame enable drop:** enable→0 at cnt=1 with act=5 → the current pulse completes all 5 clocks, and the next frame is fully low.
- **Async reset mid-pulse, plus an out-of-range channel write:**
  - reset at cnt=2 → pwm_out=0 the same cycle; act returns to 5.
  - wr_ch=3 → accepted, with no change on either channel.

Source files
------------

// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: NUM_CH servo PWM outputs sharing one frame counter.
// Targets are written at any cycle except the last of a frame. They are
// clamped to the legal servo range and move into the active width only
// at the frame boundary, optionally slew-limited. Enable is also sampled
// only at the boundary, so every pulse starts and ends on a frame grid.

// Per-channel slice: target/active width registers and the output flop.
module servo_pwm_ch #(
  parameter int CNT_W     = 32,
  parameter int MIN_PULSE = 100000,
  parameter int MAX_PULSE = 200000,
  parameter int NEUTRAL   = 150000,
  parameter int SLEW_STEP = 0
) (
  input  logic             clock_clk,
  input  logic             reset_low,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wr_pulse_i,
  input  logic             bnd_i,
  input  logic             en_d_i,
  input  logic [CNT_W-1:0] cnt_d_i,
  output logic             pwm_o,
  output logic             settled_o
);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0] NEUT_C = CNT_W'(NEUTRAL);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(SLEW_STEP);

  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] diff;
  logic             pwm_q, pwm_d;

  // Clamp an accepted write into the legal range and latch it as target.
  always_comb begin
    tgt_d = tgt_q;
    if (wr_en_i) begin
      if (wr_pulse_i < MIN_C)      tgt_d = MIN_C;
      else if (wr_pulse_i > MAX_C) tgt_d = MAX_C;
      else                         tgt_d = wr_pulse_i;
    end
  end

  // At the boundary, step the active width toward the target; never overshoot.
  always_comb begin
    act_d = act_q;
    diff  = (tgt_q > act_q) ? (tgt_q - act_q) : (act_q - tgt_q);
    if (bnd_i) begin
      if (SLEW_STEP == 0 || diff <= STEP_C) act_d = tgt_q;
      else if (tgt_q > act_q)               act_d = act_q + STEP_C;
      else                                  act_d = act_q - STEP_C;
    end
  end

  // Output is computed from next-state values so it lines up with cnt.
  always_comb begin
    pwm_d = en_d_i && (cnt_d_i < act_d);
  end

  // Channel state registers.
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      tgt_q <= NEUT_C;
      act_q <= NEUT_C;
      pwm_q <= 1'b0;
    end else begin
      tgt_q <= tgt_d;
      act_q <= act_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign settled_o = (act_q == tgt_q);
endmodule

module servo_pwm_bank #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter int CNT_W     = 32,
  parameter int PERIOD    = 2000000,
  parameter int MIN_PULSE = 100000,
  parameter int MAX_PULSE = 200000,
  parameter int NEUTRAL   = 150000,
  parameter int SLEW_STEP = 0
) (
  input  logic              clock_clk,
  input  logic              reset_low,
  input  logic              enable,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_pulse,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic [NUM_CH-1:0] settled
);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             bnd;
  logic             wr_fire;

  assign bnd      = (cnt_q == LAST_C);
  // Last cycle of a frame is reserved for the target->active transfer.
  assign wr_ready = ~bnd;
  assign wr_fire  = wr_valid & wr_ready;

  // Frame counter wraps at PERIOD; enable is only picked up at the wrap.
  always_comb begin
    cnt_d = bnd ? '0 : cnt_q + 1'b1;
    en_d  = bnd ? enable : en_q;
  end

  // Shared frame state.
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

  assign frame_start = (cnt_q == '0);

  // One slice per channel; an out-of-range wr_ch matches no slice and is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_pwm_ch #(
      .CNT_W     (CNT_W),
      .MIN_PULSE (MIN_PULSE),
      .MAX_PULSE (MAX_PULSE),
      .NEUTRAL   (NEUTRAL),
      .SLEW_STEP (SLEW_STEP)
    ) u_ch (
      .clock_clk  (clock_clk),
      .reset_low  (reset_low),
      .wr_en_i    (wr_fire && (wr_ch == CH_W'(i))),
      .wr_pulse_i (wr_pulse),
      .bnd_i      (bnd),
      .en_d_i     (en_d),
      .cnt_d_i    (cnt_d),
      .pwm_o      (pwm_out[i]),
      .settled_o  (settled[i])
    );
  end
endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench: two instances (immediate jump and SLEW_STEP=1) driven by the
// same inputs; each frame is captured as a 10-bit high/low shape per channel.
module tb_servo_pwm_bank;
  logic       clk = 1'b0;
  logic       reset_low;
  logic       enable;
  logic       wr_valid;
  logic [1:0] wr_ch;
  logic [7:0] wr_pulse;
  logic       wr_ready, wr_ready_s;
  logic [1:0] pwm_out, pwm_s;
  logic       frame_start, fs_s;
  logic [1:0] settled, set_s;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-frame write/enable plan, indexed by cnt.
  logic       pv   [10];
  logic [1:0] pch  [10];
  logic [7:0] pval [10];
  int         en_at;
  logic       en_val;

  // Captured frame.
  logic [9:0] m0, m1, q0, q1, rdy, qrdy;
  int         fs, qfs;
  logic [1:0] mst, qst;

  always #5 clk = ~clk;

  servo_pwm_bank #(.NUM_CH(2), .CH_W(2), .CNT_W(8), .PERIOD(10), .MIN_PULSE(2),
                   .MAX_PULSE(8), .NEUTRAL(5), .SLEW_STEP(0)) dut (
    .clock_clk(clk), .reset_low(reset_low), .enable(enable),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_pulse(wr_pulse),
    .pwm_out(pwm_out), .frame_start(frame_start), .settled(settled));

  servo_pwm_bank #(.NUM_CH(2), .CH_W(2), .CNT_W(8), .PERIOD(10), .MIN_PULSE(2),
                   .MAX_PULSE(8), .NEUTRAL(5), .SLEW_STEP(1)) dut_s (
    .clock_clk(clk), .reset_low(reset_low), .enable(enable),
    .wr_valid(wr_valid), .wr_ready(wr_ready_s), .wr_ch(wr_ch), .wr_pulse(wr_pulse),
    .pwm_out(pwm_s), .frame_start(fs_s), .settled(set_s));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] shp(input int n);
    logic [10:0] one;
    one = 11'd1;
    return 10'((one << n) - 11'd1);
  endfunction

  task automatic clr_plan();
    for (int k = 0; k < 10; k++) begin
      pv[k] = 1'b0; pch[k] = 2'd0; pval[k] = 8'd0;
    end
    en_at  = -1;
    en_val = 1'b0;
  endtask

  // Starts at the negedge where cnt==0, ends at the negedge of the next cnt==0.
  task automatic run_frame();
    m0 = '0; m1 = '0; q0 = '0; q1 = '0; rdy = '0; qrdy = '0; fs = 0; qfs = 0;
    for (int k = 0; k < 10; k++) begin
      m0[k] = pwm_out[0]; m1[k] = pwm_out[1];
      q0[k] = pwm_s[0];   q1[k] = pwm_s[1];
      rdy[k] = wr_ready;  qrdy[k] = wr_ready_s;
      fs  += int'(frame_start);
      qfs += int'(fs_s);
      mst = settled; qst = set_s;
      wr_valid = pv[k]; wr_ch = pch[k]; wr_pulse = pval[k];
      if (k == en_at) enable = en_val;
      @(negedge clk);
    end
    clr_plan();
  endtask

  task automatic fchk(input string tag, input int e0, input int e1, input logic [1:0] est,
                      input int s0, input int s1, input logic [1:0] sst);
    chk({tag, ".pwm0"},  32'(m0),   32'(shp(e0)));
    chk({tag, ".pwm1"},  32'(m1),   32'(shp(e1)));
    chk({tag, ".set"},   32'(mst),  32'(est));
    chk({tag, ".fs"},    32'(fs),   32'd1);
    chk({tag, ".rdy"},   32'(rdy),  32'h1FF);
    chk({tag, ".s.pwm0"}, 32'(q0),  32'(shp(s0)));
    chk({tag, ".s.pwm1"}, 32'(q1),  32'(shp(s1)));
    chk({tag, ".s.set"},  32'(qst), 32'(sst));
    chk({tag, ".s.fs"},   32'(qfs), 32'd1);
    chk({tag, ".s.rdy"},  32'(qrdy), 32'h1FF);
  endtask

  initial begin
    reset_low = 1'b0; enable = 1'b1; wr_valid = 1'b0; wr_ch = '0; wr_pulse = '0;
    clr_plan();
    repeat (3) @(negedge clk);
    chk("rst.pwm", 32'(pwm_out), 32'd0);
    chk("rst.fs",  32'(frame_start), 32'd1);
    chk("rst.set", 32'(settled), 32'd3);
    chk("rst.rdy", 32'(wr_ready), 32'd1);
    reset_low = 1'b1;

    run_frame(); fchk("F0", 0, 0, 2'b11, 0, 0, 2'b11);
    pv[3] = 1'b1; pch[3] = 2'd0; pval[3] = 8'd12;
    pv[6] = 1'b1; pch[6] = 2'd1; pval[6] = 8'd0;
    run_frame(); fchk("F1", 5, 5, 2'b00, 5, 5, 2'b00);
    run_frame(); fchk("F2", 8, 2, 2'b11, 6, 4, 2'b00);
    run_frame(); fchk("F3", 8, 2, 2'b11, 7, 3, 2'b00);
    run_frame(); fchk("F4", 8, 2, 2'b11, 8, 2, 2'b11);
    // Hold a write across the reserved cycle; it must land at cnt=0.
    pv[9] = 1'b1; pch[9] = 2'd0; pval[9] = 8'd3;
    run_frame(); fchk("F5", 8, 2, 2'b11, 8, 2, 2'b11);
    pv[0] = 1'b1; pch[0] = 2'd0; pval[0] = 8'd3;
    run_frame(); fchk("F6", 8, 2, 2'b10, 8, 2, 2'b10);
    pv[2] = 1'b1; pch[2] = 2'd0; pval[2] = 8'd5;
    run_frame(); fchk("F7", 3, 2, 2'b10, 7, 2, 2'b10);
    // Drop enable mid-frame: this pulse completes, next frame is dark.
    en_at = 1; en_val = 1'b0;
    run_frame(); fchk("F8", 5, 2, 2'b11, 6, 2, 2'b10);
    pv[3] = 1'b1; pch[3] = 2'd1; pval[3] = 8'd7;
    en_at = 5; en_val = 1'b1;
    run_frame(); fchk("F9", 0, 0, 2'b01, 0, 0, 2'b01);
    run_frame(); fchk("F10", 5, 7, 2'b11, 5, 3, 2'b01);

    // Async reset in the middle of a pulse.
    repeat (2) @(negedge clk);
    chk("pre.pwm",   32'(pwm_out), 32'd3);
    chk("pre.s.pwm", 32'(pwm_s),   32'd3);
    reset_low = 1'b0;
    #1;
    chk("arst.pwm",   32'(pwm_out), 32'd0);
    chk("arst.s.pwm", 32'(pwm_s),   32'd0);
    chk("arst.fs",    32'(frame_start), 32'd1);
    chk("arst.set",   32'(settled), 32'd3);
    @(negedge clk);
    reset_low = 1'b1;
    pv[4] = 1'b1; pch[4] = 2'd3; pval[4] = 8'd2;
    run_frame(); fchk("R0", 0, 0, 2'b11, 0, 0, 2'b11);
    run_frame(); fchk("R1", 5, 5, 2'b11, 5, 5, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
